instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 188 ++++++++++++++++++
 tb/tb_instr_fetch.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch -- in-order instruction fetch front end.
//
// Issues word-aligned fetch requests to instruction memory and pairs each
// in-order response with the address it was fetched from. The pair goes into
// a small instruction queue that feeds decode. Fetches are credit limited:
// outstanding requests plus queued instructions never exceed QDEPTH, so a
// returning response always has a free queue slot.
//
// A redirect reloads the fetch PC and flushes the queue and the tag FIFO.
// Responses still in flight at that point are discarded as they come back,
// counted off by a drop counter.
//
// Parameters
//   RESET_PC  fetch PC loaded on reset
//   QDEPTH    instruction queue depth / credit limit (power of 2, >= 2)
//
// Ports
//   clock, reset                     rising-edge clock, synchronous active-high reset
//   imem_req_valid/ready/addr        fetch request channel
//   imem_rsp_valid/data              in-order fetch response
//   redirect_valid/pc                branch / jump / trap redirect
//   inst_valid/ready/data/pc         instruction stream to decode
//   stall_cycles                     cycles decode was ready but starved
//
// Build option
//   FETCH_STALL_CNT_EN  when defined, stall_cycles is a saturating counter;
//                       otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] stall_cycles
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  // Drop count accumulates across back-to-back redirects while memory is slow;
  // 16 bits leaves ample headroom over QDEPTH per redirect.
  localparam int unsigned DW = 16;
  localparam logic [CW:0] QD = (CW+1)'(QDEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d;      // live outstanding requests (= tag FIFO count)
  logic [DW-1:0] drop_q, drop_d;    // in-flight responses to discard
  logic [PW-1:0] tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
  logic [PW-1:0] q_wp_q, q_wp_d, q_rp_q, q_rp_d;
  logic [CW-1:0] cnt_q, cnt_d;      // instruction queue occupancy

  logic [31:0] tag_mem  [QDEPTH];
  logic [31:0] qpc_mem  [QDEPTH];
  logic [31:0] qdat_mem [QDEPTH];

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  logic credit_ok, req_fire, rsp_live, rsp_drop, rsp_keep, push, pop;

  // Occupancy is taken before this cycle's pop, so credit is conservative.
  assign credit_ok = ({1'b0, out_q} + {1'b0, cnt_q}) < QD;

  assign imem_req_valid = !reset && !redirect_valid && credit_ok;
  assign imem_req_addr  = reset ? RESET_PC : pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing live or pending-drop outstanding is ignored.
  assign rsp_live = imem_rsp_valid && !reset;
  assign rsp_drop = rsp_live && (drop_q != '0);
  assign rsp_keep = rsp_live && (drop_q == '0) && (out_q != '0);
  assign push     = rsp_keep && !redirect_valid;

  assign inst_valid = !reset && !redirect_valid && (cnt_q != '0);
  assign inst_data  = reset ? 32'h0 : qdat_mem[q_rp_q];
  assign inst_pc    = reset ? 32'h0 : qpc_mem[q_rp_q];
  assign pop        = inst_valid && inst_ready;

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d     = pc_q;
    out_d    = out_q;
    drop_d   = drop_q;
    tag_wp_d = tag_wp_q;
    tag_rp_d = tag_rp_q;
    q_wp_d   = q_wp_q;
    q_rp_d   = q_rp_q;
    cnt_d    = cnt_q;
    if (redirect_valid) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      out_d    = '0;
      tag_wp_d = '0;
      tag_rp_d = '0;
      q_wp_d   = '0;
      q_rp_d   = '0;
      cnt_d    = '0;
      // Everything memory still owes us becomes garbage, minus the one
      // response (live or already doomed) that lands this very cycle.
      drop_d   = drop_q + DW'(out_q) - DW'(rsp_drop || rsp_keep);
    end else begin
      if (req_fire) begin
        pc_d     = pc_q + 32'd4;
        tag_wp_d = tag_wp_q + PW'(1);
      end
      if (rsp_drop) drop_d = drop_q - DW'(1);
      if (rsp_keep) tag_rp_d = tag_rp_q + PW'(1);
      out_d = out_q + CW'(req_fire) - CW'(rsp_keep);
      if (push) q_wp_d = q_wp_q + PW'(1);
      if (pop)  q_rp_d = q_rp_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      tag_wp_q <= '0;
      tag_rp_q <= '0;
      q_wp_q   <= '0;
      q_rp_q   <= '0;
      cnt_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      tag_wp_q <= tag_wp_d;
      tag_rp_q <= tag_rp_d;
      q_wp_q   <= q_wp_d;
      q_rp_q   <= q_rp_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage arrays need no reset: pointers and counts define validity.
  always_ff @(posedge clock) begin
    if (req_fire) tag_mem[tag_wp_q] <= pc_q;
    if (push) begin
      qpc_mem[q_wp_q]  <= tag_mem[tag_rp_q];
      qdat_mem[q_wp_q] <= imem_rsp_data;
    end
  end

  // Low address bits of a redirect target are forced to word alignment.
  logic unused_rpc_lo;
  assign unused_rpc_lo = ^redirect_pc[1:0];

  // ---------------------------------------------------------------------------
  // Fetch-starvation counter
  // ---------------------------------------------------------------------------
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (inst_ready && !inst_valid && (stall_q != 32'hFFFF_FFFF))
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned QDEPTH   = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] stall_cycles;

  instr_fetch #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  exp_t        exp_q[$];   // scoreboard: instructions decode should see, in order
  pend_t       pend[$];    // memory model: accepted requests awaiting response
  logic [31:0] seen[$];    // log of delivered PCs for directed checks

  int vectors = 0, miscompares = 0;
  int cyc = 0, last_due = 0, n_acc = 0;
  int lat_lo = 1, lat_hi = 1;
  bit in_rst = 1'b0;
  logic [31:0] m_pc = RESET_PC;   // reference fetch PC

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_seen(input string nm, input int idx, input logic [31:0] exp);
    if (seen.size() <= idx) begin
      vectors++; miscompares++;
      $display("FAIL %s: no instruction #%0d delivered, expected pc %h", nm, idx, exp);
    end else chk(nm, seen[idx], exp);
  endtask

  // One clock cycle: drive inputs, run the memory and reference models,
  // then return after the monitor has sampled this cycle.
  task automatic step(input bit rst, input bit rv, input logic [31:0] rpc,
                      input bit rq, input bit ir);
    pend_t p;
    exp_t  e;
    int    d;
    @(negedge clock);
    reset = rst; redirect_valid = rv; redirect_pc = rpc;
    imem_req_ready = rq; inst_ready = ir;
    if (rst) begin
      pend.delete(); last_due = 0;
      imem_rsp_valid = 1'($urandom_range(1, 0));   // must be ignored
      imem_rsp_data  = $urandom;
    end else if (pend.size() != 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      imem_rsp_valid = 1'b1; imem_rsp_data = memf(p.addr);
    end else begin
      imem_rsp_valid = 1'b0; imem_rsp_data = $urandom;
    end
    #1;
    if (rst) begin
      chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
      chk("rst_req_addr",  imem_req_addr, RESET_PC);
      chk("rst_inst_valid", 32'(inst_valid), 32'h0);
      chk("rst_inst_data", inst_data, 32'h0);
      chk("rst_inst_pc",   inst_pc, 32'h0);
      if (in_rst) chk("rst_stall", stall_cycles, 32'h0);
      exp_q.delete(); m_pc = RESET_PC;
    end else if (rv) begin
      chk("rdr_req_valid",  32'(imem_req_valid), 32'h0);
      chk("rdr_inst_valid", 32'(inst_valid), 32'h0);
      exp_q.delete(); m_pc = {rpc[31:2], 2'b00};
    end else if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, m_pc);
      e.pc = m_pc; e.data = memf(m_pc);
      exp_q.push_back(e);
      d = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (d < last_due) d = last_due;
      last_due = d;
      p.addr = imem_req_addr; p.due = d;
      pend.push_back(p);
      m_pc = m_pc + 32'd4;
      n_acc++;
    end
    in_rst = rst;
    cyc++;
    #2;
  endtask

  // Monitor: compares every delivered instruction against the scoreboard.
  always @(negedge clock) begin
    #2;
    if (!reset && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL inst_unexpected: got pc %h data %h, expected none", inst_pc, inst_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("inst_pc", inst_pc, e.pc);
        chk("inst_data", inst_data, e.data);
      end
      seen.push_back(inst_pc);
    end
  end

  task automatic do_reset();
    step(1, 0, 32'h0, 1, 1);
    step(1, 0, 32'h0, 1, 1);
  endtask

  initial begin
    logic [31:0] a0, rpc;
    int r;

    // Streaming: one instruction per cycle from cycle 3 after reset.
    lat_lo = 1; lat_hi = 1;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      step(0, 0, 32'h0, 1, 1);
      if (k >= 3) begin
        chk("stream_valid", 32'(inst_valid), 32'h1);
        chk("stream_pc", inst_pc, 32'(4 * (k - 3)));
      end
    end

    // Credit limit with decode blocked.
    do_reset();
    n_acc = 0;
    for (int k = 0; k < 12; k++) step(0, 0, 32'h0, 1, 0);
    chk("credit_accepts", 32'(n_acc), 32'(QDEPTH));
    chk("credit_block", 32'(imem_req_valid), 32'h0);
    seen.delete();
    for (int k = 0; k < 8; k++) step(0, 0, 32'h0, 0, 1);
    chk("credit_pops", 32'(seen.size()), 32'd4);
    for (int k = 0; k < 4; k++) chk_seen("credit_order", k, 32'(4 * k));

    // Redirect with two responses in flight (latency 3).
    lat_lo = 3; lat_hi = 3;
    do_reset();
    step(0, 0, 32'h0, 1, 1);
    step(0, 0, 32'h0, 1, 1);
    seen.delete();
    step(0, 1, 32'h0000_0040, 1, 1);
    for (int k = 0; k < 20 && seen.size() == 0; k++) step(0, 0, 32'h0, 1, 1);
    chk_seen("rdr_first_pc", 0, 32'h0000_0040);

    // Request address held while memory back-pressures.
    lat_lo = 1; lat_hi = 1;
    do_reset();
    step(0, 0, 32'h0, 1, 1);
    a0 = imem_req_addr;
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 32'h0, 0, 1);
      chk("hold_valid", 32'(imem_req_valid), 32'h1);
      chk("hold_addr", imem_req_addr, 32'h4);
    end
    step(0, 0, 32'h0, 1, 1);

    // Fetch PC wrap around 2^32 (misaligned target gets aligned).
    seen.delete();
    step(0, 1, 32'hFFFF_FFFA, 1, 1);
    for (int k = 0; k < 10; k++) step(0, 0, 32'h0, 1, 1);
    chk_seen("wrap0", 0, 32'hFFFF_FFF8);
    chk_seen("wrap1", 1, 32'hFFFF_FFFC);
    chk_seen("wrap2", 2, 32'h0000_0000);

    // Starvation counter: memory not ready for 10 cycles after reset.
    do_reset();
    for (int k = 0; k < 10; k++) step(0, 0, 32'h0, 0, 1);
    step(0, 0, 32'h0, 1, 1);
    step(0, 0, 32'h0, 1, 1);
    step(0, 0, 32'h0, 0, 1);
`ifdef FETCH_STALL_CNT_EN
    chk("stall_count", stall_cycles, 32'd12);
`else
    chk("stall_count", stall_cycles, 32'd0);
`endif

    // Randomised traffic with random latency, redirects and resets.
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(999, 0));
      if (r < 5) do_reset();
      else if (r < 35) begin
        rpc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
        step(0, 1, rpc, $urandom_range(3, 0) != 0, $urandom_range(9, 0) < 7);
      end else
        step(0, 0, 32'h0, $urandom_range(3, 0) != 0, $urandom_range(9, 0) < 7);
    end

    // Drain: every accepted fetch must have been delivered.
    for (int k = 0; k < 30; k++) step(0, 0, 32'h0, 0, 1);
    chk("drain_expected_left", 32'(exp_q.size()), 32'h0);
    chk("drain_mem_pending", 32'(pend.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
